// File: rtl/result_checker.sv
// End-of-test checker: after halt and a drain period it compares the register
// file and a DM answer window against a golden ROM. Optional first-error log: RESULT_CHECKER_ERR_LOG_EN.
module result_checker #(
    parameter int                DATA_W       = 32,
    parameter int                ADDR_W       = 16,
    parameter int                NUM_REGS     = 32,
    parameter int                NUM_WORDS    = 64,
    parameter logic [ADDR_W-1:0] ANSWER_START = 16'h9000,
    parameter int                DRAIN_CYCLES = 8,
    parameter int                MAX_CYCLES   = 1000000,
    parameter int                ERR_W        = 16,
    localparam int               GOLD_W       = $clog2(NUM_REGS + NUM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              halt_i,
    output logic [4:0]        reg_rd_idx_o,
    input  logic [DATA_W-1:0] reg_rd_data_i,
    output logic [ADDR_W-1:0] dm_rd_addr_o,
    input  logic [DATA_W-1:0] dm_rd_data_i,
    output logic [GOLD_W-1:0] gold_addr_o,
    input  logic [DATA_W-1:0] gold_data_i,
`ifdef RESULT_CHECKER_ERR_LOG_EN
    output logic              first_err_valid_o,
    output logic              first_err_is_mem_o,
    output logic [GOLD_W-1:0] first_err_idx_o,
    output logic [DATA_W-1:0] first_err_exp_o,
    output logic [DATA_W-1:0] first_err_act_o,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [ERR_W-1:0]  err_count_o
);
    localparam int CYC_W = $clog2(MAX_CYCLES + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_REG, S_MEM, S_FLUSH, S_DONE} state_t;

    state_t            state_q;
    logic [CYC_W-1:0]  cyc_q;
    logic [DRN_W-1:0]  drain_q;
    logic [4:0]        reg_rd_idx_q;
    logic [ADDR_W-1:0] dm_rd_addr_q;
    logic [GOLD_W-1:0] gold_addr_q;
    logic              cmp_vld_q, cmp_mem_q;
    logic              busy_q, done_q, pass_q, timeout_q;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [DATA_W-1:0] cmp_act;
    logic              mism;

    // Read data returns one cycle after the address, so compares trail issues by a cycle.
    always_comb begin
        cmp_act     = cmp_mem_q ? dm_rd_data_i : reg_rd_data_i;
        mism        = cmp_vld_q && (cmp_act != gold_data_i);
        err_count_d = err_count_q;
        if (mism && (err_count_q != '1))
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_RUN;
            cyc_q        <= '0;
            drain_q      <= '0;
            reg_rd_idx_q <= '0;
            dm_rd_addr_q <= '0;
            gold_addr_q  <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_mem_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_count_q  <= '0;
        end else begin
            cmp_vld_q   <= 1'b0;
            err_count_q <= err_count_d;
            case (state_q)
                S_RUN: begin
                    cyc_q <= cyc_q + 1'b1;
                    if (halt_i) begin
                        state_q <= S_DRAIN;
                        drain_q <= DRN_W'(DRAIN_CYCLES - 1);
                        busy_q  <= 1'b1;
                    end else if (cyc_q == CYC_W'(MAX_CYCLES - 1)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q      <= S_REG;
                        reg_rd_idx_q <= '0;
                        gold_addr_q  <= '0;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                S_REG: begin
                    cmp_vld_q <= 1'b1;
                    cmp_mem_q <= 1'b0;
                    if (gold_addr_q == GOLD_W'(NUM_REGS - 1)) begin
                        if (NUM_WORDS == 0) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q      <= S_MEM;
                            dm_rd_addr_q <= ANSWER_START;
                            gold_addr_q  <= GOLD_W'(NUM_REGS);
                        end
                    end else begin
                        reg_rd_idx_q <= reg_rd_idx_q + 5'd1;
                        gold_addr_q  <= gold_addr_q + 1'b1;
                    end
                end
                S_MEM: begin
                    cmp_vld_q <= 1'b1;
                    cmp_mem_q <= 1'b1;
                    if (gold_addr_q == GOLD_W'(NUM_REGS + NUM_WORDS - 1)) begin
                        state_q <= S_FLUSH;
                    end else begin
                        dm_rd_addr_q <= dm_rd_addr_q + ADDR_W'(4);
                        gold_addr_q  <= gold_addr_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_count_d == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef RESULT_CHECKER_ERR_LOG_EN
    logic [GOLD_W-1:0] cmp_idx_q;
    logic              fe_valid_q, fe_is_mem_q;
    logic [GOLD_W-1:0] fe_idx_q;
    logic [DATA_W-1:0] fe_exp_q, fe_act_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_idx_q   <= '0;
            fe_valid_q  <= 1'b0;
            fe_is_mem_q <= 1'b0;
            fe_idx_q    <= '0;
            fe_exp_q    <= '0;
            fe_act_q    <= '0;
        end else begin
            cmp_idx_q <= gold_addr_q;
            if (mism && !fe_valid_q) begin
                fe_valid_q  <= 1'b1;
                fe_is_mem_q <= cmp_mem_q;
                fe_idx_q    <= cmp_idx_q;
                fe_exp_q    <= gold_data_i;
                fe_act_q    <= cmp_act;
            end
        end
    end

    assign first_err_valid_o  = fe_valid_q;
    assign first_err_is_mem_o = fe_is_mem_q;
    assign first_err_idx_o    = fe_idx_q;
    assign first_err_exp_o    = fe_exp_q;
    assign first_err_act_o    = fe_act_q;
`endif

    assign reg_rd_idx_o = reg_rd_idx_q;
    assign dm_rd_addr_o = dm_rd_addr_q;
    assign gold_addr_o  = gold_addr_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign err_count_o  = err_count_q;
endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: two small instances (A: 16-bit errors at 0x9000,
// B: 2-bit errors at 0xFFFC) with behavioural regfile/DM/golden models.
module tb_result_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, haltA = 1'b0, haltB = 1'b0;
    logic [4:0]  ridxA, ridxB;
    logic [15:0] daddrA, daddrB;
    logic [2:0]  gaA, gaB;
    logic [31:0] rdA, rdB, ddA, ddB, gdA, gdB;
    logic        busyA, doneA, passA, toA, busyB, doneB, passB, toB;
    logic [15:0] errA;
    logic [1:0]  errB;
`ifdef RESULT_CHECKER_ERR_LOG_EN
    logic        fevA, fimA, fevB, fimB;
    logic [2:0]  fidxA, fidxB;
    logic [31:0] fexpA, factA, fexpB, factB;
`endif
    logic [31:0] rfA[4], dmA[4], goldA[8], rfB[4], dmB[4], goldB[8];

    result_checker #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(4), .NUM_WORDS(4), .ANSWER_START(16'h9000),
                     .DRAIN_CYCLES(8), .MAX_CYCLES(100), .ERR_W(16)) dutA (
        .clk_i(clk), .rst_i(rst), .halt_i(haltA), .reg_rd_idx_o(ridxA), .reg_rd_data_i(rdA),
        .dm_rd_addr_o(daddrA), .dm_rd_data_i(ddA), .gold_addr_o(gaA), .gold_data_i(gdA),
`ifdef RESULT_CHECKER_ERR_LOG_EN
        .first_err_valid_o(fevA), .first_err_is_mem_o(fimA), .first_err_idx_o(fidxA),
        .first_err_exp_o(fexpA), .first_err_act_o(factA),
`endif
        .busy_o(busyA), .done_o(doneA), .pass_o(passA), .timeout_o(toA), .err_count_o(errA));

    result_checker #(.DATA_W(32), .ADDR_W(16), .NUM_REGS(4), .NUM_WORDS(4), .ANSWER_START(16'hFFFC),
                     .DRAIN_CYCLES(8), .MAX_CYCLES(100), .ERR_W(2)) dutB (
        .clk_i(clk), .rst_i(rst), .halt_i(haltB), .reg_rd_idx_o(ridxB), .reg_rd_data_i(rdB),
        .dm_rd_addr_o(daddrB), .dm_rd_data_i(ddB), .gold_addr_o(gaB), .gold_data_i(gdB),
`ifdef RESULT_CHECKER_ERR_LOG_EN
        .first_err_valid_o(fevB), .first_err_is_mem_o(fimB), .first_err_idx_o(fidxB),
        .first_err_exp_o(fexpB), .first_err_act_o(factB),
`endif
        .busy_o(busyB), .done_o(doneB), .pass_o(passB), .timeout_o(toB), .err_count_o(errB));

    // Synchronous-read memories: data valid one cycle after the address.
    wire [15:0] offA = daddrA - 16'h9000;
    wire [15:0] offB = daddrB - 16'hFFFC;
    always @(posedge clk) begin
        rdA <= rfA[ridxA[1:0]];  ddA <= dmA[offA[3:2]];  gdA <= goldA[gaA];
        rdB <= rfB[ridxB[1:0]];  ddB <= dmB[offB[3:2]];  gdB <= goldB[gaB];
    end

    bit sel = 1'b0;
    wire [4:0]  ridx_s  = sel ? ridxB : ridxA;
    wire [15:0] daddr_s = sel ? daddrB : daddrA;
    wire [2:0]  ga_s    = sel ? gaB : gaA;
    wire        busy_s  = sel ? busyB : busyA;
    wire        done_s  = sel ? doneB : doneA;
    wire        pass_s  = sel ? passB : passA;
    wire        to_s    = sel ? toB : toA;
    wire [15:0] err_s   = sel ? {14'b0, errB} : errA;

    typedef struct {bit is_mem; logic [4:0] ridx; logic [15:0] daddr; logic [2:0] ga;} rd_t;
    typedef struct {logic [15:0] err; bit pass;} res_t;
    rd_t  sb[$];
    res_t rq[$];

    int ncmp = 0, nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; haltA = 1'b0; haltB = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy_s, 0);   check({tag, "_done"}, done_s, 0);
        check({tag, "_pass"}, pass_s, 0);   check({tag, "_tmo"}, to_s, 0);
        check({tag, "_err"}, err_s, 0);     check({tag, "_ridx"}, ridx_s, 0);
        check({tag, "_daddr"}, daddr_s, 0); check({tag, "_gaddr"}, ga_s, 0);
    endtask

    // Expected read order and final verdict, derived from the bench models.
    task automatic push_expect();
        int e;
        logic [15:0] base;
        e = 0;
        base = sel ? 16'hFFFC : 16'h9000;
        for (int i = 0; i < 4; i++) begin
            if (sel ? (rfB[i] != goldB[i]) : (rfA[i] != goldA[i])) e++;
            if (sel ? (dmB[i] != goldB[4+i]) : (dmA[i] != goldA[4+i])) e++;
            sb.push_back('{1'b0, 5'(i), 16'h0, 3'(i)});
        end
        for (int j = 0; j < 4; j++) sb.push_back('{1'b1, 5'd3, base + 16'(4*j), 3'(4+j)});
        if (sel && e > 3) e = 3;
        rq.push_back('{16'(e), e == 0});
    endtask

    // Starts at cycle 0 after reset release.
    task automatic run_compare(input int halt_cyc);
        rd_t  e;
        res_t r;
        repeat (halt_cyc) tick();
        if (sel) haltB = 1'b1; else haltA = 1'b1;
        push_expect();
        tick();
        check("busy_rise", busy_s, 1);
        check("done_early", done_s, 0);
        repeat (8) begin
            tick();
            haltA = 1'b0; haltB = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            e = sb.pop_front();
            if (!e.is_mem) check("reg_idx", ridx_s, e.ridx);
            else           check("dm_addr", daddr_s, e.daddr);
            check("gold_addr", ga_s, e.ga);
            check("busy_cmp", busy_s, 1);
            tick();
        end
        check("flush_done", done_s, 0);
        check("flush_busy", busy_s, 1);
        tick();
        r = rq.pop_front();
        check("done", done_s, 1);
        check("done_busy", busy_s, 0);
        check("err_count", err_s, r.err);
        check("pass", pass_s, r.pass);
        check("timeout", to_s, 0);
        if (sel) haltB = 1'b1; else haltA = 1'b1;
        repeat (3) tick();
        haltA = 1'b0; haltB = 1'b0;
        tick();
        check("done_sticky", done_s, 1);
        check("err_hold", err_s, r.err);
        check("busy_hold", busy_s, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            goldA[i] = 32'h1000_0000 + 32'(i * 17);
            goldB[i] = 32'h2000_0000 + 32'(i * 29);
        end
        for (int i = 0; i < 4; i++) begin
            rfA[i] = goldA[i]; dmA[i] = goldA[4+i];
            rfB[i] = goldB[i]; dmB[i] = goldB[4+i];
        end

        // reset state
        sel = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check_idle("rst");
`ifdef RESULT_CHECKER_ERR_LOG_EN
        check("rst_fev", fevA, 0); check("rst_fexp", fexpA, 0); check("rst_fact", factA, 0);
`endif
        rst = 1'b0;

        // all entries match
        run_compare(20);

        // register 2 and DM word 0x9008 mismatched
        rfA[2] = 32'hDEADBEEF; goldA[2] = 32'h0; dmA[2] = 32'h55;
        do_reset();
        run_compare(20);
`ifdef RESULT_CHECKER_ERR_LOG_EN
        check("log_valid", fevA, 1); check("log_is_mem", fimA, 0); check("log_idx", fidxA, 2);
        check("log_exp", fexpA, 32'h0); check("log_act", factA, 32'hDEADBEEF);
`endif
        goldA[2] = 32'h1000_0000 + 32'(2 * 17); rfA[2] = goldA[2]; dmA[2] = goldA[6];

        // watchdog without halt
        do_reset();
        repeat (99) tick();
        check("wd_done_early", done_s, 0);
        tick();
        check("wd_done", done_s, 1);
        check("wd_timeout", to_s, 1);
        check("wd_pass", pass_s, 0);
        check("wd_busy", busy_s, 0);
        check("wd_ridx", ridx_s, 0);
        check("wd_daddr", daddr_s, 0);
        check("wd_gaddr", ga_s, 0);

        // every entry mismatched, 2-bit counter saturates; DM window wraps
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rfB[i] = ~goldB[i]; dmB[i] = ~goldB[4+i];
        end
        do_reset();
        run_compare(20);
`ifdef RESULT_CHECKER_ERR_LOG_EN
        check("logB_is_mem", fimB, 0); check("logB_idx", fidxB, 0);
        check("logB_exp", fexpB, goldB[0]); check("logB_act", factB, ~goldB[0]);
`endif

        // reset mid-compare, then clean re-run
        sel = 1'b0;
        rfA[1] = 32'hDEADBEEF;
        do_reset();
        repeat (20) tick();
        haltA = 1'b1;
        tick();
        haltA = 1'b0;
        repeat (14) tick();
        check("mid_daddr", daddr_s, 16'h9008);
        check("mid_err", err_s, 1);
        check("mid_busy", busy_s, 1);
        rst = 1'b1;
        tick();
        check_idle("midrst");
`ifdef RESULT_CHECKER_ERR_LOG_EN
        check("midrst_fev", fevA, 0);
`endif
        rst = 1'b0;
        rfA[1] = goldA[1];
        run_compare(20);
        check("rerun_pass", passA, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Parametrised end-of-test checker for the RISC-V pipeline CPU environment; replaces the ad-hoc compare loop in the bench with a reusable sequential engine.
- After the CPU signals halt, it waits a programmable drain period, then walks the register file and a DM answer window. Each entry is compared against a golden ROM, and the block reports error count, pass/fail and a watchdog timeout.
- It sits beside the CPU and DM, using dedicated read-only side ports.

Parameters:
- DATA_W, 32, data width of register, DM and golden words
- ADDR_W, 16, DM byte-address width
- NUM_REGS, 32, register entries compared (indices 0..NUM_REGS-1)
- NUM_WORDS, 64, DM words compared
- ANSWER_START, 16'h9000, DM byte address of first answer word
- DRAIN_CYCLES, 8, cycles waited after halt before comparing (>=1)
- MAX_CYCLES, 1000000, watchdog limit counted from reset release
- ERR_W, 16, error counter width

Ports:
- clk, in, 1: single clock, rising edge
- rst, in, 1: synchronous active-high reset
- halt, in, 1: CPU finished (level, sampled each cycle)
- reg_rd_idx, out, 5: register index to read
- reg_rd_data, in, DATA_W: register data, valid 1 cycle after reg_rd_idx
- dm_rd_addr, out, ADDR_W: DM byte address to read
- dm_rd_data, in, DATA_W: DM word, valid 1 cycle after dm_rd_addr
- gold_addr, out, clog2(NUM_REGS+NUM_WORDS): golden ROM index
- gold_data, in, DATA_W: golden word, valid 1 cycle after gold_addr
- busy, out, 1: compare sequence in progress (DRAIN, REG or MEM)
- done, out, 1: check finished, sticky until rst
- pass, out, 1: valid when done; 1 only if err_count==0 and no timeout
- timeout, out, 1: watchdog expired before halt
- err_count, out, ERR_W: mismatches found, saturating

Behaviour:
- Reset: state RUN; all counters 0; busy, done, pass, timeout, err_count = 0; all address outputs 0.
- RUN:
  - The cycle counter increments every cycle.
  - If halt=1, go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - Else, if the counter reaches MAX_CYCLES-1, go to DONE with timeout=1 and pass=0.
  - If halt and the watchdog limit occur in the same cycle, halt wins.
- DRAIN:
  - halt is ignored in this state.
  - When the drain counter reaches 0, go to REG with index i=0.
  - Exactly DRAIN_CYCLES cycles are spent in DRAIN.
- REG:
  - In cycle k, issue reg_rd_idx=k and gold_addr=k.
  - In cycle k+1, compare reg_rd_data against gold_data.
  - After issuing NUM_REGS-1, go to MEM with j=0. The final register compare overlaps the first MEM cycle.
- MEM:
  - In cycle j, issue dm_rd_addr=ANSWER_START+4*j (mod 2^ADDR_W) and gold_addr=NUM_REGS+j.
  - In cycle j+1, compare dm_rd_data against gold_data.
  - After issuing NUM_WORDS-1, perform one flush-compare cycle, then go to DONE.
  - Total compare window is NUM_REGS+NUM_WORDS+1 cycles after DRAIN.
- Compare: on inequality, err_count increments by 1 and saturates at 2^ERR_W-1.
- DONE:
  - done=1 and busy=0.
  - pass = (err_count==0) && !timeout, registered on DONE entry.
  - Remains in DONE until rst; halt toggling has no effect.
- Outputs are registered; address outputs change only on clk edges.
- rst asserted in any state (including mid-compare) returns to the reset state on the next edge, discarding partial counts.
- NUM_WORDS=0: MEM is skipped and the block goes from the last REG compare straight to DONE.

Optional Feature:
- Macro: RESULT_CHECKER_ERR_LOG_EN.
- Defined:
  - Adds outputs first_err_valid (1), first_err_is_mem (1), first_err_idx (clog2(NUM_REGS+NUM_WORDS)), first_err_exp (DATA_W) and first_err_act (DATA_W).
  - These capture the first mismatch only and hold it until rst; all are 0 at reset.
- Not defined: the ports are absent and the behaviour is otherwise identical.

Test Plan:
- NUM_REGS=4, NUM_WORDS=4, DRAIN_CYCLES=8, all models match, halt at cycle 20:
  - busy rises at cycle 21; done at cycle 21+8+9.
  - pass=1, err_count=0.
- Register 2 data 0xDEADBEEF vs golden 0x00000000, plus DM word at 0x9008 mismatched:
  - err_count=2, pass=0.
  - With ERR_LOG_EN: first_err_is_mem=0, idx=2, exp=0x00000000, act=0xDEADBEEF.
- halt never asserted, MAX_CYCLES=100:
  - done=1 and timeout=1 at cycle 100; pass=0; no read addresses issued.
- ERR_W=2, all 8 entries mismatched:
  - err_count saturates at 3; pass=0.
- rst pulsed during MEM at j=2 with 1 error already counted:
  - Next cycle all outputs are 0 and state is RUN.
  - A re-run on matching data yields pass=1.
- ANSWER_START=16'hFFFC, NUM_WORDS=2: dm_rd_addr sequence is 0xFFFC then 0x0000 (wrap).
